// File: rtl/mem_pkg.sv
// Shared types and default sizes for the burst memory access controller.
// Holds the FSM state encoding used by the controller and exposed for debug.
package mem_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 16;
   localparam int LEN_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

endpackage

// File: rtl/mac_burst_counter.sv
// Burst address/length tracker shared by read and write bursts.
// last is high while the current address is the final word of the burst.
module mac_burst_counter #(
   parameter int ADDR_W = 6,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load) begin
         addr_d = load_addr;
         cnt_d  = load_len;
      end else if (step) begin
         // Address wraps naturally at 2^ADDR_W; the count saturates at zero.
         addr_d = addr_q + ADDR_ONE;
         if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else if (ce) begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr = addr_q;
   assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Burst read/write front end for a single-port RAM with a registered read port.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic [ADDR_W-1:0] mem_add,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_r_w,
   output logic              mem_enable,
   output logic              mem_ce,
   input  logic [DATA_W-1:0] mem_data_out,
   output state_t            dbg_state
);

   state_t state_q, state_d;
   logic   rd_valid_q, rd_valid_d;
   logic   rd_last_q, rd_last_d;
   logic   issued_all_q, issued_all_d;

   logic              req_fire;
   logic              wr_fire;
   logic              rd_issue;
   logic              rd_accept;
   logic              cnt_step;
   logic [ADDR_W-1:0] addr_q;
   logic              cnt_last;

   always_comb begin
      state_d      = state_q;
      rd_valid_d   = rd_valid_q;
      rd_last_d    = rd_last_q;
      issued_all_d = issued_all_q;

      req_ready = (state_q == IDLE) && ce && !rst;
      wr_ready  = (state_q == WR) && ce && !rst;
      req_fire  = req_valid && req_ready;
      wr_fire   = wr_valid && wr_ready;
      rd_accept = rd_valid_q && rd_ready && ce && !rst;
      // A new read may only be issued when the output slot is free or being drained.
      rd_issue  = (state_q == RD) && ce && !rst && !issued_all_q &&
                  (!rd_valid_q || rd_ready);
      cnt_step  = rd_issue || wr_fire;

      if (rd_issue) begin
         rd_valid_d = 1'b1;
         rd_last_d  = cnt_last;
         if (cnt_last) begin
            issued_all_d = 1'b1;
         end
      end else if (rd_accept) begin
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (req_fire) begin
               state_d      = req_we ? WR : RD;
               issued_all_d = 1'b0;
            end
         end
         RD: begin
            if (rd_accept && rd_last_q) begin
               state_d = IDLE;
            end
         end
         WR: begin
            if (wr_fire && cnt_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         issued_all_q <= 1'b0;
      end else if (ce) begin
         state_q      <= state_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
         issued_all_q <= issued_all_d;
      end
   end

   mac_burst_counter #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_burst_counter (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .load      (req_fire),
      .load_addr (req_addr),
      .load_len  (req_len),
      .step      (cnt_step),
      .addr      (addr_q),
      .last      (cnt_last)
   );

   // The RAM's output register is the read holding register; it only changes on a new read.
   assign rd_valid    = rd_valid_q;
   assign rd_last     = rd_last_q;
   assign rd_data     = mem_data_out;
   assign mem_add     = addr_q;
   assign mem_data_in = wr_data;
   assign mem_r_w     = wr_fire;
   assign mem_enable  = rd_issue || wr_fire;
   assign mem_ce      = ce;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural RAM and reference memory.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        rd_last;
  logic [5:0]  mem_add;
  logic [15:0] mem_data_in;
  logic        mem_r_w;
  logic        mem_enable;
  logic        mem_ce;
  logic [15:0] mem_data_out;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ram [64];
  logic [15:0] ref_mem [64];
  logic [15:0] ram_q = '0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .mem_add(mem_add), .mem_data_in(mem_data_in), .mem_r_w(mem_r_w),
    .mem_enable(mem_enable), .mem_ce(mem_ce), .mem_data_out(mem_data_out),
    .dbg_state(dbg_state)
  );

  // RAM: registered read output that only changes on an enabled read
  always @(posedge clk) begin
    if (mem_ce && mem_enable) begin
      if (mem_r_w) ram[mem_add] <= mem_data_in;
      else ram_q <= ram[mem_add];
    end
  end
  assign mem_data_out = ram_q;

  task automatic send_req(input bit we, input int addr, input int len);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = 6'(addr); req_len = 4'(len);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL req_ready_accept: got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Write burst; gap_pct inserts idle wr_valid cycles, ce_word/ce_cycles pauses ce.
  task automatic do_write(input int addr, input int len, input bit fixed, input logic [15:0] base,
                          input int gap_pct, input int ce_word, input int ce_cycles);
    int i = 0, cyc = 0, ce_ctr = 0;
    logic [15:0] d;
    send_req(1'b1, addr, len);
    // send_req leaves us at the negedge of the first WR cycle
    while (i <= len && cyc < 200) begin
      d = fixed ? 16'(base + 16'(i)) : 16'($urandom);
      if (i == ce_word && ce_ctr < ce_cycles) begin
        ce = 1'b0; wr_valid = 1'b1; wr_data = d;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b0 || mem_enable !== 1'b0 || mem_ce !== 1'b0 || req_ready !== 1'b0) begin
          n_err++; $display("FAIL ce_pause: wr_ready=%b mem_enable=%b mem_ce=%b req_ready=%b want 0000",
                            wr_ready, mem_enable, mem_ce, req_ready);
        end
        ce_ctr++;
      end else begin
        ce = 1'b1;
        wr_valid = ($urandom_range(0, 99) >= gap_pct);
        wr_data = d;
        #1;
        n_cmp++;
        if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b want 1", wr_ready); end
        if (wr_valid) begin
          n_cmp++;
          if (mem_enable !== 1'b1 || mem_r_w !== 1'b1 || mem_add !== 6'((addr + i) % 64) ||
              mem_data_in !== d) begin
            n_err++; $display("FAIL wr_access %0d: en=%b rw=%b add=%0d data=%h want 1 1 %0d %h",
                              i, mem_enable, mem_r_w, mem_add, mem_data_in, (addr + i) % 64, d);
          end
          if (i == len) begin
            n_cmp++;
            if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_last_req_ready: got %b want 0", req_ready); end
          end
          ref_mem[(addr + i) % 64] = d;
          i++;
        end else begin
          n_cmp++;
          if (mem_enable !== 1'b0) begin n_err++; $display("FAIL wr_idle_enable: got %b want 0", mem_enable); end
        end
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0; ce = 1'b1;
    #1;
    n_cmp++;
    if (i != len + 1 || req_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL wr_done: words=%0d req_ready=%b state=%0d want %0d 1 IDLE",
                        i, req_ready, dbg_state, len + 1);
    end
  endtask

  // Read burst; mode 0 = always ready, 1 = stall once at word stall_word, 2 = random ready.
  task automatic do_read(input int addr, input int len, input int mode, input int stall_word,
                         input int stall_cycles);
    int acc = 0, iss = 0, cyc = 0, st_ctr = 0, first_v = -1;
    bit prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic prev_last = 1'b0;
    send_req(1'b0, addr, len);
    while (acc <= len && cyc < 300) begin
      if (mode == 1) rd_ready = !(acc == stall_word && rd_valid && st_ctr < stall_cycles);
      else if (mode == 2) rd_ready = 1'($urandom_range(0, 1));
      else rd_ready = 1'b1;
      #1;
      if (rd_valid && !rd_ready) st_ctr++;
      if (mem_enable) begin
        n_cmp++;
        if (mem_r_w !== 1'b0 || mem_add !== 6'((addr + iss) % 64) || iss > len) begin
          n_err++; $display("FAIL rd_issue %0d: rw=%b add=%0d want 0 %0d (len %0d)",
                            iss, mem_r_w, mem_add, (addr + iss) % 64, len);
        end
        iss++;
      end
      if (rd_valid && !rd_ready) begin
        n_cmp++;
        if (mem_enable !== 1'b0) begin n_err++; $display("FAIL rd_stall_enable: got %b want 0", mem_enable); end
      end
      if (prev_stall) begin
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last) begin
          n_err++; $display("FAIL rd_hold: valid=%b data=%h last=%b want 1 %h %b",
                            rd_valid, rd_data, rd_last, prev_data, prev_last);
        end
      end
      if (mode == 0 && acc > 0 && acc <= len) begin
        n_cmp++;
        if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_gap word %0d: valid=%b want 1", acc, rd_valid); end
      end
      if (rd_valid && first_v < 0) first_v = cyc;
      if (rd_valid && rd_ready) begin
        n_cmp++;
        if (rd_data !== ref_mem[(addr + acc) % 64] || rd_last !== (acc == len)) begin
          n_err++; $display("FAIL rd_word %0d: data=%h last=%b want %h %b",
                            acc, rd_data, rd_last, ref_mem[(addr + acc) % 64], acc == len);
        end
        acc++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data; prev_last = rd_last;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    #1;
    n_cmp++;
    if (acc != len + 1 || req_ready !== 1'b1 || rd_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL rd_done: words=%0d req_ready=%b rd_valid=%b state=%0d want %0d 1 0 IDLE",
                        acc, req_ready, rd_valid, dbg_state, len + 1);
    end
    if (mode == 0) begin
      n_cmp++;
      if (first_v != 1) begin n_err++; $display("FAIL rd_latency: first valid cycle %0d want 1", first_v); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b0 || mem_enable !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_held: req_ready=%b mem_enable=%b wr_ready=%b want 000",
                        req_ready, mem_enable, wr_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || req_ready !== 1'b1 || dbg_state !== IDLE ||
        mem_ce !== 1'b1 || mem_add !== 6'd0) begin
      n_err++; $display("FAIL reset_state: rd_valid=%b rd_last=%b req_ready=%b state=%0d mem_ce=%b add=%0d",
                        rd_valid, rd_last, req_ready, dbg_state, mem_ce, mem_add);
    end
  endtask

  task automatic test_write_basic();
    do_write(5, 3, 1'b1, 16'hA001, 0, -1, 0);
  endtask

  task automatic test_read_basic();
    n_cmp++;
    if (ref_mem[8] !== 16'hA004) begin n_err++; $display("FAIL ref_after_write: got %h want a004", ref_mem[8]); end
    do_read(5, 3, 0, 0, 0);
  endtask

  task automatic test_wrap();
    do_write(62, 3, 1'b0, 16'h0, 0, -1, 0);
    do_read(62, 3, 0, 0, 0);
  endtask

  task automatic test_stall();
    do_read(5, 2, 1, 0, 3);
  endtask

  task automatic test_ce_pause();
    do_write(20, 3, 1'b1, 16'hC100, 0, 1, 2);
    do_read(20, 3, 0, 0, 0);
  endtask

  task automatic test_reset_mid_read();
    send_req(1'b0, 5, 3);
    rd_ready = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[5]) begin
      n_err++; $display("FAIL rst_rd_word1: valid=%b data=%h want 1 %h", rd_valid, rd_data, ref_mem[5]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_enable !== 1'b0 || req_ready !== 1'b0 || wr_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_during: mem_enable=%b req_ready=%b wr_ready=%b want 000",
                        mem_enable, req_ready, wr_ready);
    end
    @(negedge clk);
    rst = 1'b0; rd_ready = 1'b0;
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0 || mem_enable !== 1'b0 || dbg_state !== IDLE || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_after: rd_valid=%b mem_enable=%b state=%0d req_ready=%b want 0 0 IDLE 1",
                        rd_valid, mem_enable, dbg_state, req_ready);
    end
    do_read(40, 4, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int a, l;
      a = $urandom_range(0, 63);
      l = $urandom_range(0, 15);
      do_write(a, l, 1'b0, 16'h0, 30, -1, 0);
      do_read($urandom_range(0, 63), $urandom_range(0, 15), 2, 0, 0);
      do_read(a, l, 0, 0, 0);
    end
  endtask

  initial begin
    for (int j = 0; j < 64; j++) begin
      ram[j] = 16'($urandom);
      ref_mem[j] = ram[j];
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_stall();
    test_ce_pause();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
